icache_responder: RTL

//  Cache-side end of the CPU<->ICache request interface driven by the pre-IF/IF stages.

---
 rtl/icache_responder.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/icache_responder.sv
// Direct-mapped, read-only instruction cache answering CPU fetches one word per request.
// Misses refill a full line over a burst memory port; uncached fetches become single-beat reads.
module icache_responder #(
    parameter int INDEX_W  = 8,
    parameter int OFFSET_W = 4,
    localparam int TAG_W   = 32 - INDEX_W - OFFSET_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cpu_req,
    input  logic                cpu_iscache,
    input  logic [OFFSET_W-1:0] cpu_offset,
    input  logic [INDEX_W-1:0]  cpu_index,
    input  logic [TAG_W-1:0]    cpu_tag,
    output logic                cpu_addr_ok,
    output logic                cpu_data_ok,
    output logic [31:0]         cpu_rdata,
    output logic                mem_req,
    output logic [31:0]         mem_addr,
    output logic [7:0]          mem_len,
    input  logic                mem_addr_ok,
    input  logic                mem_rvalid,
    input  logic [31:0]         mem_rdata,
    input  logic                mem_rlast
);
    localparam int LINE_WORDS = 2 ** (OFFSET_W - 2);
    localparam int WORD_W     = OFFSET_W - 2;
    localparam int NLINES     = 2 ** INDEX_W;

    typedef enum logic [2:0] {
        IDLE, LOOKUP, MISS_REQ, REFILL, UC_REQ, UC_WAIT, RESP
    } state_t;

    state_t                         state_reg;
    logic [TAG_W-1:0]               tag_reg;
    logic [INDEX_W-1:0]             idx_reg;
    logic [WORD_W-1:0]              word_reg;
    logic [WORD_W-1:0]              cnt_reg;
    logic [LINE_WORDS-1:0][31:0]    line_buf_reg;
    logic [31:0]                    resp_word_reg;
    logic                           mem_req_reg;
    logic [31:0]                    mem_addr_reg;
    logic [7:0]                     mem_len_reg;
    logic [NLINES-1:0]              valid_reg;

    logic [TAG_W-1:0]               tag_arr  [NLINES];
    logic [LINE_WORDS-1:0][31:0]    data_arr [NLINES];

    logic                           hit;
    logic                           take;
    logic                           install;
    logic [LINE_WORDS-1:0][31:0]    line_next;
    logic [31:0]                    uc_addr;
    logic                           unused_offset_bits;

    assign unused_offset_bits = ^cpu_offset[1:0];

    assign hit     = (state_reg == LOOKUP) && valid_reg[idx_reg] && (tag_arr[idx_reg] == tag_reg);
    assign take    = cpu_req && ((state_reg == IDLE) || hit);
    assign install = (state_reg == REFILL) && mem_rvalid && mem_rlast;
    assign uc_addr = {cpu_tag, cpu_index, cpu_offset[OFFSET_W-1:2], 2'b00};

    // Line buffer with the beat arriving this cycle merged in, so the last beat installs directly.
    generate
        for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_merge
            assign line_next[gi] = (cnt_reg == WORD_W'(gi)) ? mem_rdata : line_buf_reg[gi];
        end
    endgenerate

    // Acceptance is masked while reset is held so the port reads all-zero immediately.
    assign cpu_addr_ok = take && reset;
    assign cpu_data_ok = hit || (state_reg == RESP);
    assign cpu_rdata   = hit ? data_arr[idx_reg][word_reg]
                       : (state_reg == RESP) ? resp_word_reg : 32'h0;
    assign mem_req     = mem_req_reg;
    assign mem_addr    = mem_addr_reg;
    assign mem_len     = mem_len_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            tag_reg       <= '0;
            idx_reg       <= '0;
            word_reg      <= '0;
            cnt_reg       <= '0;
            line_buf_reg  <= '0;
            resp_word_reg <= '0;
            mem_req_reg   <= 1'b0;
            mem_addr_reg  <= '0;
            mem_len_reg   <= '0;
            valid_reg     <= '0;
        end else begin
            if (take) begin
                tag_reg  <= cpu_tag;
                idx_reg  <= cpu_index;
                word_reg <= cpu_offset[OFFSET_W-1:2];
            end
            case (state_reg)
                IDLE, LOOKUP: begin
                    if (state_reg == LOOKUP && !hit) begin
                        state_reg    <= MISS_REQ;
                        mem_req_reg  <= 1'b1;
                        mem_addr_reg <= {tag_reg, idx_reg, {OFFSET_W{1'b0}}};
                        mem_len_reg  <= 8'(LINE_WORDS - 1);
                    end else if (take) begin
                        if (cpu_iscache) begin
                            state_reg <= LOOKUP;
                        end else begin
                            state_reg    <= UC_REQ;
                            mem_req_reg  <= 1'b1;
                            mem_addr_reg <= uc_addr;
                            mem_len_reg  <= 8'd0;
                        end
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                MISS_REQ: begin
                    if (mem_addr_ok) begin
                        mem_req_reg <= 1'b0;
                        cnt_reg     <= '0;
                        state_reg   <= REFILL;
                    end
                end
                REFILL: begin
                    if (mem_rvalid) begin
                        line_buf_reg <= line_next;
                        cnt_reg      <= cnt_reg + WORD_W'(1);
                        if (mem_rlast) begin
                            valid_reg[idx_reg] <= 1'b1;
                            resp_word_reg      <= line_next[word_reg];
                            state_reg          <= RESP;
                        end
                    end
                end
                UC_REQ: begin
                    if (mem_addr_ok) begin
                        mem_req_reg <= 1'b0;
                        state_reg   <= UC_WAIT;
                    end
                end
                UC_WAIT: begin
                    if (mem_rvalid) begin
                        resp_word_reg <= mem_rdata;
                        state_reg     <= RESP;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Tag and data storage carry no reset; only the valid bits decide whether a line can hit.
    always_ff @(posedge clk) begin
        if (install) begin
            tag_arr[idx_reg]  <= tag_reg;
            data_arr[idx_reg] <= line_next;
        end
    end
endmodule
